i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Parameters
REQ-001 NUM_REQ, 4, number of requesters (2..8).
REQ-002 START_WAIT, 64, max clock cycles between ctrl_init_transaction and ctrl_busy rising.
REQ-003 RUN_TIMEOUT, 2_000_000, max clock cycles ctrl_busy may stay high.

Interface
REQ-004 clock  in  1  single clock; all logic on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  NUM_REQ  per-requester transaction request level; held until done.
REQ-007 req_rw  in  NUM_REQ  per-requester direction; 1 = write.
REQ-008 req_address  in  8*NUM_REQ  per-requester address byte; slice i at [8i+7:8i].
REQ-009 req_data  in  32*NUM_REQ  per-requester write data; slice i at [32i+31:32i].
REQ-010 req_bytesend  in  4*NUM_REQ  per-requester byte count; slice i at [4i+3:4i].
REQ-011 gnt  out  NUM_REQ  one-hot grant, high from capture until done.
REQ-012 done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-013 err  out  2  status valid with done: 00 ok, 01 nack, 10 start timeout, 11 run timeout.
REQ-014 ctrl_init_transaction  out  1  one-cycle start pulse to the I2C controller.
REQ-015 ctrl_rw, ctrl_address, ctrl_data, ctrl_bytesend  out  1/8/32/4  latched transaction fields.
REQ-016 ctrl_busy  in  1  controller transaction in progress.
REQ-017 ctrl_nack  in  1  controller saw NACK; sampled on the busy falling edge.

Function
REQ-018 States: IDLE, CAPTURE, START, WAIT_BUSY, RUN, DONE.
REQ-019 IDLE: if any req bit is set, select the winner round-robin starting at index rr_ptr+1 (mod NUM_REQ), then go to CAPTURE; otherwise stay.
REQ-020 CAPTURE: latch the winner's rw/address/data/bytesend into ctrl_* and assert the one-hot gnt; go to START.
REQ-021 START: assert ctrl_init_transaction for exactly one cycle, clear the timer, and go to WAIT_BUSY.
REQ-022 WAIT_BUSY: if ctrl_busy is 1, clear the timer and go to RUN; if the timer reaches START_WAIT-1 with busy still low, set err=10 and go to DONE.
REQ-023 RUN: when ctrl_busy is 0, set err={1'b0, ctrl_nack} and go to DONE; if the timer reaches RUN_TIMEOUT-1, set err=11 and go to DONE.
REQ-024 DONE: pulse done[winner] for one cycle, set rr_ptr to the winner, deassert gnt, and go to IDLE.
REQ-025 ctrl_* fields shall remain stable from CAPTURE through DONE; changes on req_* after capture shall be ignored.
REQ-026 If the winner drops req after capture, the transaction shall still complete and done shall still pulse.
REQ-027 The timer shall be $clog2(RUN_TIMEOUT) bits wide and saturate; it shall not wrap.
REQ-028 Minimum request-to-init latency is 2 cycles (IDLE -> CAPTURE -> START); back-to-back transactions shall be separated by at least 1 IDLE cycle.
REQ-029 A requester shall not win twice in a row while any other req bit is set.
REQ-030 After reset, rr_ptr = NUM_REQ-1, so requester 0 has first priority.
REQ-031 ctrl_busy already high in IDLE shall block arbitration until it falls.

Reset
REQ-032 Asserting reset shall immediately force state=IDLE, gnt=0, done=0, err=00, ctrl_init_transaction=0, ctrl_*=0, timer=0, and rr_ptr=NUM_REQ-1.
REQ-033 Reset asserted mid-transaction shall abandon the transaction; no done pulse shall be issued.
REQ-034 Arbitration shall restart from REQ-030 in the first cycle after reset deasserts.

Verification
REQ-035 req=4'b0101 from reset; busy modelled as 10 cycles -> grant 0 first, then 2; each gets one done with err=00; exactly one init pulse per transaction.
REQ-036 All four req held high continuously -> grant order 0,1,2,3,0; no requester granted twice consecutively.
REQ-037 ctrl_busy never rises after init -> done after START_WAIT cycles with err=10; the next request is serviced normally.
REQ-038 ctrl_busy held high for RUN_TIMEOUT cycles -> err=11 and done; ctrl_nack=1 at the busy falling edge -> err=01.
REQ-039 req_data changes during RUN -> ctrl_data unchanged; reset pulsed during RUN -> all outputs 0 and no done pulse.

Source files
------------

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that lets several requesters share one I2C controller.
// Each granted request is sequenced through start, busy-wait and completion with two timeouts.
module i2c_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int START_WAIT  = 64,
   parameter int RUN_TIMEOUT = 2_000_000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ-1:0]      req_rw,
   input  logic [8*NUM_REQ-1:0]    req_address,
   input  logic [32*NUM_REQ-1:0]   req_data,
   input  logic [4*NUM_REQ-1:0]    req_bytesend,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [NUM_REQ-1:0]      done,
   output logic [1:0]              err,
   output logic                    ctrl_init_transaction,
   output logic                    ctrl_rw,
   output logic [7:0]              ctrl_address,
   output logic [31:0]             ctrl_data,
   output logic [3:0]              ctrl_bytesend,
   input  logic                    ctrl_busy,
   input  logic                    ctrl_nack
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int TW = $clog2(RUN_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_CAPTURE, S_START, S_WAIT_BUSY, S_RUN, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   winner_q, winner_d, rr_ptr_q, rr_ptr_d, pick_idx;
   logic            pick_found;
   logic [PW:0]     cand;
   logic [TW-1:0]   timer_q, timer_d, timer_inc;
   logic [1:0]      err_q, err_d;
   logic            ctrl_rw_q, ctrl_rw_d;
   logic [7:0]      ctrl_address_q, ctrl_address_d;
   logic [31:0]     ctrl_data_q, ctrl_data_d;
   logic [3:0]      ctrl_bytesend_q, ctrl_bytesend_d;
   logic            sel_rw;
   logic [7:0]      sel_address;
   logic [31:0]     sel_data;
   logic [3:0]      sel_bytesend;
   logic [NUM_REQ-1:0] winner_oh;

   // Search starts one past the last winner so nobody wins twice while others wait.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = rr_ptr_q;
      cand       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
         if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
         if (!pick_found && req[cand[PW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[PW-1:0];
         end
      end
   end

   always_comb begin
      sel_rw       = 1'b0;
      sel_address  = '0;
      sel_data     = '0;
      sel_bytesend = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == PW'(i)) begin
            sel_rw       = req_rw[i];
            sel_address  = req_address[8*i +: 8];
            sel_data     = req_data[32*i +: 32];
            sel_bytesend = req_bytesend[4*i +: 4];
         end
      end
   end

   assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;

   always_comb begin
      state_d         = state_q;
      winner_d        = winner_q;
      rr_ptr_d        = rr_ptr_q;
      timer_d         = timer_q;
      err_d           = err_q;
      ctrl_rw_d       = ctrl_rw_q;
      ctrl_address_d  = ctrl_address_q;
      ctrl_data_d     = ctrl_data_q;
      ctrl_bytesend_d = ctrl_bytesend_q;
      case (state_q)
         S_IDLE: begin
            // Fields are taken on entry to CAPTURE so they are valid alongside gnt.
            if (pick_found && !ctrl_busy) begin
               winner_d        = pick_idx;
               ctrl_rw_d       = sel_rw;
               ctrl_address_d  = sel_address;
               ctrl_data_d     = sel_data;
               ctrl_bytesend_d = sel_bytesend;
               state_d         = S_CAPTURE;
            end
         end
         S_CAPTURE: state_d = S_START;
         S_START: begin
            timer_d = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (ctrl_busy) begin
               timer_d = '0;
               state_d = S_RUN;
            end else if (timer_q == TW'(START_WAIT-1)) begin
               err_d   = 2'b10;
               state_d = S_DONE;
            end else begin
               timer_d = timer_inc;
            end
         end
         S_RUN: begin
            if (!ctrl_busy) begin
               err_d   = {1'b0, ctrl_nack};
               state_d = S_DONE;
            end else if (timer_q == TW'(RUN_TIMEOUT-1)) begin
               err_d   = 2'b11;
               state_d = S_DONE;
            end else begin
               timer_d = timer_inc;
            end
         end
         S_DONE: begin
            rr_ptr_d = winner_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         winner_q        <= '0;
         rr_ptr_q        <= PW'(NUM_REQ-1);
         timer_q         <= '0;
         err_q           <= 2'b00;
         ctrl_rw_q       <= 1'b0;
         ctrl_address_q  <= '0;
         ctrl_data_q     <= '0;
         ctrl_bytesend_q <= '0;
      end else begin
         state_q         <= state_d;
         winner_q        <= winner_d;
         rr_ptr_q        <= rr_ptr_d;
         timer_q         <= timer_d;
         err_q           <= err_d;
         ctrl_rw_q       <= ctrl_rw_d;
         ctrl_address_q  <= ctrl_address_d;
         ctrl_data_q     <= ctrl_data_d;
         ctrl_bytesend_q <= ctrl_bytesend_d;
      end
   end

   assign winner_oh             = NUM_REQ'(1) << winner_q;
   assign gnt                   = (state_q != S_IDLE) ? winner_oh : '0;
   assign done                  = (state_q == S_DONE) ? winner_oh : '0;
   assign err                   = err_q;
   assign ctrl_init_transaction = (state_q == S_START);
   assign ctrl_rw               = ctrl_rw_q;
   assign ctrl_address          = ctrl_address_q;
   assign ctrl_data             = ctrl_data_q;
   assign ctrl_bytesend         = ctrl_bytesend_q;
endmodule

// File: tb/tb_i2c_arbiter.sv
// Randomized scoreboard bench for i2c_arbiter: requesters and a controller model drive the DUT,
// a round-robin reference model predicts grants/fields/status, and a monitor checks each done.
module tb_i2c_arbiter;
   localparam int N  = 4;
   localparam int SW = 16;
   localparam int RT = 200;

   logic            clock, reset;
   logic [N-1:0]    req, req_rw;
   logic [8*N-1:0]  req_address;
   logic [32*N-1:0] req_data;
   logic [4*N-1:0]  req_bytesend;
   logic [N-1:0]    gnt, done;
   logic [1:0]      err;
   logic            ctrl_init_transaction, ctrl_rw;
   logic [7:0]      ctrl_address;
   logic [31:0]     ctrl_data;
   logic [3:0]      ctrl_bytesend;
   logic            ctrl_busy, ctrl_nack;

   i2c_arbiter #(.NUM_REQ(N), .START_WAIT(SW), .RUN_TIMEOUT(RT)) dut (
      .clock(clock), .reset(reset), .req(req), .req_rw(req_rw),
      .req_address(req_address), .req_data(req_data), .req_bytesend(req_bytesend),
      .gnt(gnt), .done(done), .err(err), .ctrl_init_transaction(ctrl_init_transaction),
      .ctrl_rw(ctrl_rw), .ctrl_address(ctrl_address), .ctrl_data(ctrl_data),
      .ctrl_bytesend(ctrl_bytesend), .ctrl_busy(ctrl_busy), .ctrl_nack(ctrl_nack)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          w;
      logic        rw;
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  b;
   } txn_t;

   txn_t       exp_q[$];
   logic [1:0] experr_q[$];
   int checks = 0, passes = 0, cyc = 0, dones = 0, mode = 0;
   int rr_m = N-1, cur_w = -1, cphase = 0, wcnt = 0, hcnt = 0;
   int init_cnt = 0, init_cyc = 0;
   bit free = 1'b1, started0 = 1'b0;
   logic [N-1:0] pending = '0;
   logic plan_nack = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act === expv) passes++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, expv);
   endtask

   task automatic scramble(input int i);
      req_rw[i]              = 1'($urandom_range(0, 1));
      req_address[8*i +: 8]  = 8'($urandom);
      req_data[32*i +: 32]   = $urandom;
      req_bytesend[4*i +: 4] = 4'($urandom);
   endtask

   task automatic raise(input int i);
      req[i]     = 1'b1;
      pending[i] = 1'b1;
      scramble(i);
   endtask

   task automatic check_reset_outputs();
      check("rst_gnt", 64'(gnt), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_init", 64'(ctrl_init_transaction), 64'd0);
      check("rst_ctrl_fields", 64'({ctrl_rw, ctrl_address, ctrl_data, ctrl_bytesend}), 64'd0);
   endtask

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // Stimulus: requesters, controller model and the reference arbitration model.
   initial begin : stim
      bit free_now, never;
      int d, len, w, r;
      req = '0; req_rw = '0; req_address = '0; req_data = '0; req_bytesend = '0;
      ctrl_busy = 1'b0; ctrl_nack = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            req = '0; pending = '0; free = 1'b1; rr_m = N-1; cur_w = -1;
            cphase = 0; ctrl_busy = 1'b0; ctrl_nack = 1'b0;
            exp_q.delete(); experr_q.delete();
         end else begin
            free_now = free;
            if (done != '0) begin
               free = 1'b1;
               dones++;
               if (cur_w >= 0) begin
                  if (mode != 1) begin
                     req[cur_w] = 1'b0;
                     pending[cur_w] = 1'b0;
                  end else scramble(cur_w);
               end
               cur_w = -1;
            end
            if (ctrl_init_transaction) begin
               never = 1'b0; plan_nack = 1'b0;
               case (mode)
                  0: begin d = 1; len = 10; end
                  1: begin d = int'($urandom_range(1, 3)); len = int'($urandom_range(1, 8)); end
                  default: begin
                     d = int'($urandom_range(1, SW-2));
                     r = int'($urandom_range(0, 9));
                     never = (r == 0);
                     len = (r == 1) ? RT + int'($urandom_range(1, 30)) : int'($urandom_range(1, 40));
                     plan_nack = 1'($urandom_range(0, 1));
                  end
               endcase
               if (never) experr_q.push_back(2'b10);
               else if (len > RT) experr_q.push_back(2'b11);
               else experr_q.push_back({1'b0, plan_nack});
               if (never) cphase = 0;
               else begin cphase = 1; wcnt = d; end
            end
            if (cphase == 1) begin
               if (wcnt == 0) begin
                  ctrl_busy = 1'b1; ctrl_nack = 1'($urandom_range(0, 1));
                  hcnt = len; cphase = 2;
               end else wcnt--;
            end else if (cphase == 2) begin
               hcnt--;
               if (hcnt == 0) begin
                  ctrl_busy = 1'b0; ctrl_nack = plan_nack; cphase = 0;
               end
            end
            case (mode)
               0: if (!started0) begin raise(0); raise(2); started0 = 1'b1; end
               1: for (int i = 0; i < N; i++) if (!req[i]) raise(i);
               2: for (int i = 0; i < N; i++)
                     if (!pending[i] && $urandom_range(0, 5) == 0) raise(i);
               default: ;
            endcase
            // A captured requester may change its fields or drop req; neither should matter.
            if (mode == 2 && cur_w >= 0) begin
               scramble(cur_w);
               if ($urandom_range(0, 3) == 0) req[cur_w] = 1'b0;
            end
            if (free_now && req != '0 && !ctrl_busy) begin
               w = -1;
               for (int k = 1; k <= N; k++)
                  if (w < 0 && req[(rr_m + k) % N]) w = (rr_m + k) % N;
               exp_q.push_back('{w, req_rw[w], req_address[8*w +: 8], req_data[32*w +: 32],
                                 req_bytesend[4*w +: 4]});
               rr_m = w; free = 1'b0; cur_w = w;
            end
         end
      end
   end

   // Monitor: compares every done pulse against the scoreboard.
   initial begin : monitor
      txn_t t;
      logic [1:0] e;
      forever begin
         @(negedge clock);
         if (reset) init_cnt = 0;
         else begin
            if (ctrl_init_transaction) begin
               init_cnt++;
               init_cyc = cyc;
               if (exp_q.size() > 0)
                  check("init_fields", 64'({ctrl_rw, ctrl_address, ctrl_data, ctrl_bytesend}),
                        64'({exp_q[0].rw, exp_q[0].a, exp_q[0].d, exp_q[0].b}));
               else check("init_unexpected", 64'(ctrl_init_transaction), 64'd0);
            end
            if (done != '0) begin
               if (exp_q.size() == 0 || experr_q.size() == 0)
                  check("done_unexpected", 64'(done), 64'd0);
               else begin
                  t = exp_q.pop_front();
                  e = experr_q.pop_front();
                  check("done_winner", 64'(done), 64'(1) << t.w);
                  check("gnt_at_done", 64'(gnt), 64'(1) << t.w);
                  check("err_status", 64'(err), 64'(e));
                  check("ctrl_fields_stable", 64'({ctrl_rw, ctrl_address, ctrl_data, ctrl_bytesend}),
                        64'({t.rw, t.a, t.d, t.b}));
                  check("init_per_txn", 64'(init_cnt), 64'd1);
                  if (e == 2'b10) check("start_timeout_latency", 64'(cyc - init_cyc), 64'(SW + 1));
               end
               init_cnt = 0;
            end
         end
      end
   end

   task automatic wait_dones(input int n, input int budget);
      int target, spent;
      target = dones + n;
      spent = 0;
      while (dones < target && spent < budget) begin
         @(posedge clock);
         spent++;
      end
      check("done_count_in_budget", 64'(dones >= target), 64'd1);
   endtask

   task automatic wait_idle(input int budget);
      int spent;
      bit idle;
      spent = 0;
      idle = 1'b0;
      while (!idle && spent < budget) begin
         @(posedge clock);
         spent++;
         idle = (exp_q.size() == 0) && (pending == '0) && !ctrl_busy && free;
      end
      check("drain_in_budget", 64'(idle), 64'd1);
   endtask

   initial begin : main
      int spent;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 check_reset_outputs();
      @(negedge clock);
      #1 reset = 1'b0;

      mode = 0;
      wait_dones(2, 500);
      mode = 1;
      wait_dones(10, 2000);
      mode = 3;
      wait_idle(2000);

      mode = 2;
      repeat (4000) @(posedge clock);
      mode = 3;
      wait_idle(3000);

      mode = 2;
      spent = 0;
      while (!(ctrl_busy && cur_w >= 0) && spent < 3000) begin
         @(negedge clock);
         spent++;
      end
      check("reached_run_for_reset", 64'(ctrl_busy && cur_w >= 0), 64'd1);
      @(posedge clock);
      #2 reset = 1'b1;
      #1 check_reset_outputs();
      repeat (3) @(posedge clock);
      @(negedge clock);
      #1 reset = 1'b0;

      repeat (800) @(posedge clock);
      mode = 3;
      wait_idle(3000);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
